pong_match_controller: RTL and testbench
========================================

// Module: pong_match_controller
// PURPOSE
//  Match sequencer for the two-player pong game: serve, rally, point, game-over. Counts the
//  frame-end tick, consumes the game module's hit/miss flags, keeps scores and rally speed.
//  Gates ball motion through ball_enable and recentres the ball through serve_req.
// PARAMETERS
//  WIN_SCORE        7    first player to reach this score wins (1..15)
//  SERVE_FRAMES     60   frame ticks from serve_req to ball release
//  POINT_FRAMES     63   frame ticks the point/miss display is held
//  HITS_PER_SPEEDUP 4    paddle hits per speed_level step
//  MAX_SPEED        3    speed_level saturation value
// PORTS
//  Clock         in   1  system clock; all state on rising edge
//  Reset         in   1  asynchronous, active-low reset
//  frame_tick    in   1  1-cycle pulse at end of each frame (xpos==0, ypos==480)
//  start         in   1  debounced start button, level
//  hit1, hit2    in   1  paddle 1/2 hit flag, level (may stay high many cycles)
//  miss1, miss2  in   1  point_reset1/2 from game module: player 1/2 missed
//  score1,score2 out  4  current scores
//  speed_level   out  2  rally speed, 0..MAX_SPEED
//  ball_enable   out  1  ball may move
//  serve_req     out  1  1-cycle pulse: recentre ball
//  serve_dir     out  1  0 = toward player 2 (top), 1 = toward player 1 (bottom)
//  game_over     out  1  high in GAME_OVER
//  winner        out  1  0 = player 1, 1 = player 2; valid while game_over
//  state         out  3  current FSM state, for debug/display
// BEHAVIOUR
//  Reset: state=IDLE; scores, speed_level, rally_hits, frame counter = 0; ball_enable,
//   serve_req, serve_dir, game_over, winner = 0. Reset mid-game aborts immediately.
//  start, hit1/2, miss1/2: only the rising edge (registered previous value) counts.
//  IDLE: ball_enable=0. start edge -> scores=0, SERVE.
//  SERVE: serve_req pulses exactly on the entry cycle; rally_hits=0, speed_level=0;
//   ball_enable=0; SERVE_FRAMES frame ticks counted -> PLAY (ball_enable=1 next cycle).
//  PLAY: hit edge -> rally_hits+1 (8-bit, saturates at 255);
//   speed_level = min(rally_hits/HITS_PER_SPEEDUP, MAX_SPEED), updated 1 cycle after edge.
//   miss1 edge -> score2+1, serve_dir=1; miss2 edge -> score1+1, serve_dir=0; -> POINT.
//   miss1 and miss2 edges same cycle: no score, serve_dir unchanged, -> SERVE (let).
//   hit and miss edges same cycle: miss wins, hit ignored.
//  POINT: ball_enable=0; hold POINT_FRAMES ticks; then scorer's score==WIN_SCORE ->
//   GAME_OVER (winner set), else SERVE. Scores never exceed WIN_SCORE.
//  GAME_OVER: game_over=1, ball_enable=0; start edge -> scores=0, serve_dir=0, SERVE.
//  Edges arriving outside PLAY are ignored (no score, no hit count).
//  frame_tick coincident with a state entry counts toward the new state's hold.
// CONFIGURATION
//  PONG_PAUSE_EN defined: extra port pause (in, 1, debounced level); each rising edge
//   toggles a paused flag, only in SERVE/PLAY/POINT. While paused: ball_enable=0, frame
//   counter frozen, hit/miss edges ignored; unpause resumes same state and count.
//   Paused flag cleared on reset and on entry to GAME_OVER.
//  Undefined: no pause port, no paused flag; behaviour as above.
// STRUCTURE
//  pong_pkg.vh: state encodings ST_IDLE=0, ST_SERVE=1, ST_PLAY=2, ST_POINT=3,
//   ST_GAME_OVER=4; SCORE_W=4; SPEED_W=2; shared with the score display and game module.
//  Sub-module pong_event_edge: per-input rising-edge detector (async active-low reset),
//   instanced for start, hit1, hit2, miss1, miss2 (and pause when PONG_PAUSE_EN).
//  Frame hold counter, FSM and score registers stay in this module.
// TESTING (SERVE_FRAMES=4, POINT_FRAMES=3 in bench)
//  Reset, start pulse -> serve_req one cycle, state SERVE; after 4 frame_ticks
//   ball_enable=1, state PLAY.
//  PLAY, hit1 high 200 cycles, 9 hits total -> rally_hits=9, speed_level=2; 20 hits ->
//   speed_level=3 (saturated).
//  PLAY, miss1 edge -> score2=1, serve_dir=1, POINT; 3 ticks -> SERVE, speed_level=0.
//  miss1 and miss2 same cycle -> scores unchanged, state SERVE, serve_req pulse.
//  score1=6, miss2 edge -> score1=7, after POINT hold game_over=1, winner=0; start ->
//   scores 0, SERVE.
//  Reset low mid-PLAY, score 3-2 -> all outputs zero, IDLE, asynchronously.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller, score display and game module.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int SPEED_W = 2;
  localparam int HITS_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  // Bit positions in the edge-detector bank.
  localparam int EV_START = 0;
  localparam int EV_HIT1  = 1;
  localparam int EV_HIT2  = 2;
  localparam int EV_MISS1 = 3;
  localparam int EV_MISS2 = 4;
  localparam int EV_PAUSE = 5;

  function automatic logic [HITS_W-1:0] sat_inc_hits(input logic [HITS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pong_event_edge.sv
// Rising-edge detector for one level input; the previous value is registered.
module pong_event_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= in_i;
  end

  assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve, rally, point, game-over, with scores and rally speed.
// Optional pause input and paused flag when PONG_PAUSE_EN is defined.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE        = 7,
  parameter int SERVE_FRAMES     = 60,
  parameter int POINT_FRAMES     = 63,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int MAX_SPEED        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               hit1,
  input  logic               hit2,
  input  logic               miss1,
  input  logic               miss2,
`ifdef PONG_PAUSE_EN
  input  logic               pause,
`endif
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [SPEED_W-1:0] speed_level,
  output logic               ball_enable,
  output logic               serve_req,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

`ifdef PONG_PAUSE_EN
  localparam int NUM_EV = 6;
`else
  localparam int NUM_EV = 5;
`endif
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);

  logic [NUM_EV-1:0] ev_in, ev;

  assign ev_in[EV_START] = start;
  assign ev_in[EV_HIT1]  = hit1;
  assign ev_in[EV_HIT2]  = hit2;
  assign ev_in[EV_MISS1] = miss1;
  assign ev_in[EV_MISS2] = miss2;
`ifdef PONG_PAUSE_EN
  assign ev_in[EV_PAUSE] = pause;
`endif

  for (genvar g = 0; g < NUM_EV; g++) begin : g_edge
    pong_event_edge u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (ev_in[g]),
      .rise_o(ev[g])
    );
  end

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [HITS_W-1:0]  hits_q, hits_d, speed_raw;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               dir_q, dir_d, win_q, win_d, req_q, req_d;
  logic               paused, tick, hit_e, m1_e, m2_e;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    hits_d  = hits_q;
    dir_d   = dir_q;
    win_d   = win_q;
    tick    = frame_tick & ~paused;
    hit_e   = (ev[EV_HIT1] | ev[EV_HIT2]) & ~paused;
    m1_e    = ev[EV_MISS1] & ~paused;
    m2_e    = ev[EV_MISS2] & ~paused;

    unique case (state_q)
      ST_IDLE: begin
        if (ev[EV_START]) begin
          s1_d    = '0;
          s2_d    = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
          else                     cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_PLAY: begin
        // Simultaneous misses are a let; a miss always beats a hit.
        if (m1_e && m2_e) begin
          state_d = ST_SERVE;
        end else if (m1_e) begin
          s2_d    = (s2_q == WIN) ? s2_q : s2_q + 1'b1;
          dir_d   = 1'b1;
          state_d = ST_POINT;
        end else if (m2_e) begin
          s1_d    = (s1_q == WIN) ? s1_q : s1_q + 1'b1;
          dir_d   = 1'b0;
          state_d = ST_POINT;
        end else if (hit_e) begin
          hits_d  = sat_inc_hits(hits_q);
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (cnt_q == POINT_LAST) begin
            // serve_dir still names the scorer: 1 means player 2 took the point.
            if ((dir_q ? s2_q : s1_q) == WIN) begin
              state_d = ST_GAME_OVER;
              win_d   = dir_q;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_GAME_OVER: begin
        if (ev[EV_START]) begin
          s1_d    = '0;
          s2_d    = '0;
          dir_d   = 1'b0;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    req_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    if (req_d) hits_d = '0;
    speed_raw = hits_d / HITS_W'(HITS_PER_SPEEDUP);
    speed_d   = (speed_raw >= HITS_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                   : speed_raw[SPEED_W-1:0];
  end

`ifdef PONG_PAUSE_EN
  logic paused_q, paused_d;

  always_comb begin
    paused_d = paused_q;
    if (state_d == ST_GAME_OVER)
      paused_d = 1'b0;
    else if (ev[EV_PAUSE] &&
             (state_q == ST_SERVE || state_q == ST_PLAY || state_q == ST_POINT))
      paused_d = ~paused_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) paused_q <= 1'b0;
    else        paused_q <= paused_d;
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      hits_q  <= '0;
      speed_q <= '0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      hits_q  <= hits_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      req_q   <= req_d;
    end
  end

  assign score1      = s1_q;
  assign score2      = s2_q;
  assign speed_level = speed_q;
  assign ball_enable = (state_q == ST_PLAY) & ~paused;
  assign serve_req   = req_q;
  assign serve_dir   = dir_q;
  assign game_over   = (state_q == ST_GAME_OVER);
  assign winner      = win_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: vector table, directed match sequences, random play vs model.
module tb_pong_match_controller;

  localparam int SF  = 4;
  localparam int PF  = 3;
  localparam int WIN = 7;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0;
  logic       hit1 = 1'b0, hit2 = 1'b0, miss1 = 1'b0, miss2 = 1'b0;
  logic [3:0] score1, score2;
  logic [1:0] speed_level;
  logic       ball_enable, serve_req, serve_dir, game_over, winner;
  logic [2:0] state;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  pong_match_controller #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
    .HITS_PER_SPEEDUP(4), .MAX_SPEED(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .hit1(hit1), .hit2(hit2), .miss1(miss1), .miss2(miss2),
    .score1(score1), .score2(score2), .speed_level(speed_level),
    .ball_enable(ball_enable), .serve_req(serve_req), .serve_dir(serve_dir),
    .game_over(game_over), .winner(winner), .state(state)
  );

  // Match model: phase 0 idle, 1 serve, 2 play, 3 point, 4 game over.
  int ms, msc1, msc2, mhits, mheld;
  bit mdir, mwin, mreq;
  bit p_st, p_h1, p_h2, p_m1, p_m2;

  function automatic void chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
  endfunction

  function automatic void model_reset();
    ms = 0; msc1 = 0; msc2 = 0; mhits = 0; mheld = 0;
    mdir = 0; mwin = 0; mreq = 0;
    p_st = 0; p_h1 = 0; p_h2 = 0; p_m1 = 0; p_m2 = 0;
  endfunction

  function automatic void model_step();
    bit es, eh, e1, e2;
    int nx;
    es = start && !p_st;
    eh = (hit1 && !p_h1) || (hit2 && !p_h2);
    e1 = miss1 && !p_m1;
    e2 = miss2 && !p_m2;
    p_st = start; p_h1 = hit1; p_h2 = hit2; p_m1 = miss1; p_m2 = miss2;
    nx = ms;
    case (ms)
      0: if (es) begin msc1 = 0; msc2 = 0; nx = 1; end
      1: if (frame_tick) begin mheld++; if (mheld == SF) nx = 2; end
      2: if (e1 && e2) nx = 1;
         else if (e1) begin if (msc2 < WIN) msc2++; mdir = 1; nx = 3; end
         else if (e2) begin if (msc1 < WIN) msc1++; mdir = 0; nx = 3; end
         else if (eh && mhits < 255) mhits++;
      3: if (frame_tick) begin
           mheld++;
           if (mheld == PF) begin
             if ((mdir ? msc2 : msc1) == WIN) begin nx = 4; mwin = mdir; end
             else nx = 1;
           end
         end
      4: if (es) begin msc1 = 0; msc2 = 0; mdir = 0; nx = 1; end
      default: nx = 0;
    endcase
    mreq = (nx == 1) && (ms != 1);
    if (nx != ms) mheld = 0;
    if (mreq) mhits = 0;
    ms = nx;
  endfunction

  function automatic int pack_out(input int st, input int s1, input int s2, input int sp,
                                  input bit be, input bit rq, input bit dr, input bit go,
                                  input bit wn);
    return (st << 16) | (s1 << 12) | (s2 << 8) | (sp << 5) | (int'(be) << 4) |
           (int'(rq) << 3) | (int'(dr) << 2) | (int'(go) << 1) | int'(wn);
  endfunction

  task automatic step();
    int msp;
    model_step();
    @(posedge clk);
    #1;
    msp = (mhits / 4 > 3) ? 3 : mhits / 4;
    chk("model", pack_out(state, score1, score2, speed_level, ball_enable, serve_req,
                          serve_dir, game_over, winner),
        pack_out(ms, msc1, msc2, msp, ms == 2, mreq, mdir, ms == 4, mwin));
  endtask

  task automatic cyc(input bit tk, input bit st, input bit h1, input bit h2,
                     input bit m1, input bit m2);
    frame_tick = tk; start = st; hit1 = h1; hit2 = h2; miss1 = m1; miss2 = m2;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  // Serve to play, one player misses, hold the point display.
  task automatic play_point(input bit p1_missed);
    ticks(SF);
    cyc(0, 0, 0, 0, p1_missed, !p1_missed);
    cyc(0, 0, 0, 0, 0, 0);
    ticks(PF);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_score1"}, score1, 0);
    chk({tag, "_score2"}, score2, 0);
    chk({tag, "_speed"}, speed_level, 0);
    chk({tag, "_ball_en"}, ball_enable, 0);
    chk({tag, "_serve_req"}, serve_req, 0);
    chk({tag, "_serve_dir"}, serve_dir, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask

  typedef struct {
    bit tk, st, h1, h2, m1, m2;
    int est, es1, es2, esp;
    bit ebe, ereq, edir;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    //          tk st h1 h2 m1 m2  st s1 s2 sp be rq dir
    tbl[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 0,  2, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 0, 0,  2, 0, 0, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 0,  2, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0,  2, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 0,  3, 0, 1, 1, 0, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 1, 0,  3, 0, 1, 1, 0, 0, 1};
    tbl[14] = '{1, 0, 0, 0, 0, 0,  3, 0, 1, 1, 0, 0, 1};
    tbl[15] = '{1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 1};
    tbl[16] = '{0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].tk, tbl[i].st, tbl[i].h1, tbl[i].h2, tbl[i].m1, tbl[i].m2);
      chk($sformatf("vec%0d_state", i), state, tbl[i].est);
      chk($sformatf("vec%0d_score1", i), score1, tbl[i].es1);
      chk($sformatf("vec%0d_score2", i), score2, tbl[i].es2);
      chk($sformatf("vec%0d_speed", i), speed_level, tbl[i].esp);
      chk($sformatf("vec%0d_ball_en", i), ball_enable, tbl[i].ebe);
      chk($sformatf("vec%0d_serve_req", i), serve_req, tbl[i].ereq);
      chk($sformatf("vec%0d_serve_dir", i), serve_dir, tbl[i].edir);
    end

    // Rally speed: 9 hits (last one held high) then saturation at 20 hits.
    ticks(SF);
    chk("rally_play", state, 2);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 200; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("speed_9hits", speed_level, 2);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, 0, i[0], 0, 0);
      cyc(0, 0, !i[0], 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk("speed_sat", speed_level, 3);

    // Let: both players miss on the same cycle.
    cyc(0, 0, 0, 0, 1, 1);
    chk("let_state", state, 1);
    chk("let_serve_req", serve_req, 1);
    chk("let_score1", score1, 0);
    chk("let_score2", score2, 1);
    chk("let_speed", speed_level, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("let_req_pulse", serve_req, 0);

    // Player 1 wins 7-1.
    for (int i = 0; i < 7; i++) play_point(1'b0);
    chk("win_score1", score1, 7);
    chk("win_game_over", game_over, 1);
    chk("win_winner", winner, 0);
    chk("win_state", state, 4);
    chk("win_ball_en", ball_enable, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("restart_state", state, 1);
    chk("restart_score1", score1, 0);
    chk("restart_score2", score2, 0);
    chk("restart_req", serve_req, 1);
    chk("restart_dir", serve_dir, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // 3-2 mid-play, then asynchronous reset between clock edges.
    play_point(1'b0); play_point(1'b1); play_point(1'b0);
    play_point(1'b1); play_point(1'b0);
    ticks(SF);
    chk("pre_rst_state", state, 2);
    chk("pre_rst_score1", score1, 3);
    chk("pre_rst_score2", score2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random play against the model.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
